// File: rtl/cache_miss_ctrl_pkg.sv
// Shared definitions for the cache miss controller and the direct-mapped cache it drives.
// State encoding, index/tag split and default timeout.
package cache_miss_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_MISS_RD,
    ST_FILL,
    ST_WR_MEM,
    ST_WR_CACHE,
    ST_RESP
  } state_t;

  localparam int INDEX_W         = 7;
  localparam int TAG_LSB         = INDEX_W;
  localparam int TIMEOUT_DEFAULT = 255;
  localparam int WAIT_W          = 8;

  // Value of the wait counter in the last cycle a memory ack can still be accepted.
  function automatic logic [WAIT_W-1:0] wait_limit(input int timeout);
    return WAIT_W'(timeout - 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; clear takes priority over increment.
module sat_counter
  import cache_miss_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= sat_inc(cnt);
    end
  end

endmodule

// File: rtl/cache_miss_ctrl.sv
// Single-outstanding CPU byte-access controller: cache probe on reads, memory fetch and
// line fill on misses, write-through with write-allocate, and hit/miss statistics.
module cache_miss_ctrl
  import cache_miss_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = 16
) (
  input  logic              clk_1,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_valid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,
  output logic [ADDR_W-1:0] cache_addr,
  output logic              cache_w_en,
  output logic [DATA_W-1:0] cache_wdata,
  input  logic              cache_hit,
  input  logic [DATA_W-1:0] cache_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = wait_limit(TIMEOUT);

  state_t              state, nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   data_q;
  logic                err_q;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [ADDR_W-1:0]   cache_addr_q;
  logic                waiting;
  logic                timeout;
  logic                drive_cache;
  logic                hit_inc;
  logic                miss_inc;

  assign waiting     = (state == ST_MISS_RD) || (state == ST_WR_MEM);
  assign timeout     = waiting && !mem_ack && (wait_cnt == WAIT_LIMIT);
  assign drive_cache = (state == ST_LOOKUP) || (state == ST_FILL) || (state == ST_WR_CACHE);

  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      data_q       <= '0;
      err_q        <= 1'b0;
      wait_cnt     <= '0;
      cache_addr_q <= '0;
    end else begin
      state <= nxt;
      if (state == ST_IDLE && cpu_req) begin
        addr_q  <= cpu_addr;
        we_q    <= cpu_we;
        wdata_q <= cpu_wdata;
        err_q   <= 1'b0;
      end
      if (hit_inc) data_q <= cache_rdata;
      if (state == ST_MISS_RD && mem_ack) data_q <= mem_rdata;
      if (timeout) err_q <= 1'b1;
      wait_cnt <= waiting ? wait_cnt + 1'b1 : '0;
      // cache_addr keeps the last presented address while the cache is not being driven
      if (drive_cache) cache_addr_q <= addr_q;
    end
  end

  always_comb begin
    nxt      = state;
    hit_inc  = 1'b0;
    miss_inc = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cpu_req) nxt = cpu_we ? ST_WR_MEM : ST_LOOKUP;
      end
      ST_LOOKUP: begin
        // Anything other than a clean 1 on cache_hit is treated as a miss
        if (cache_hit) begin
          hit_inc = 1'b1;
          nxt     = ST_RESP;
        end else begin
          miss_inc = 1'b1;
          nxt      = ST_MISS_RD;
        end
      end
      ST_MISS_RD: begin
        if (mem_ack)      nxt = ST_FILL;
        else if (timeout) nxt = ST_RESP;
      end
      ST_FILL:     nxt = ST_RESP;
      ST_WR_MEM: begin
        if (mem_ack)      nxt = ST_WR_CACHE;
        else if (timeout) nxt = ST_RESP;
      end
      ST_WR_CACHE: nxt = ST_RESP;
      ST_RESP:     nxt = ST_IDLE;
      default:     nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cpu_ready   = (state == ST_IDLE);
    cpu_valid   = (state == ST_RESP);
    cpu_err     = (state == ST_RESP) && err_q;
    cpu_rdata   = (state == ST_RESP && !we_q && !err_q) ? data_q : '0;
    cache_addr  = drive_cache ? addr_q : cache_addr_q;
    cache_w_en  = (state == ST_FILL) || (state == ST_WR_CACHE);
    cache_wdata = '0;
    if (state == ST_FILL)     cache_wdata = data_q;
    if (state == ST_WR_CACHE) cache_wdata = wdata_q;
    mem_req     = waiting;
    mem_we      = (state == ST_WR_MEM);
    mem_addr    = waiting ? addr_q : '0;
    mem_wdata   = (state == ST_WR_MEM) ? wdata_q : '0;
  end

  sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk (clk_1),
    .rst (rst),
    .clr (stat_clr),
    .inc (hit_inc),
    .cnt (hit_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk (clk_1),
    .rst (rst),
    .clr (stat_clr),
    .inc (miss_inc),
    .cnt (miss_cnt)
  );

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Bench for cache_miss_ctrl: directed and randomized accesses checked against a
// transaction-level model of latency, data, error and counter behaviour.
module tb_cache_miss_ctrl;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 255;
  localparam int CNT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk_1;
  logic              rst;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ready;
  logic              cpu_valid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_err;
  logic [ADDR_W-1:0] cache_addr;
  logic              cache_w_en;
  logic [DATA_W-1:0] cache_wdata;
  logic              cache_hit;
  logic [DATA_W-1:0] cache_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              stat_clr;
  logic [CNT_W-1:0]  hit_cnt;
  logic [CNT_W-1:0]  miss_cnt;

  cache_miss_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk_1(clk_1), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_valid(cpu_valid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .cache_addr(cache_addr), .cache_w_en(cache_w_en), .cache_wdata(cache_wdata),
    .cache_hit(cache_hit), .cache_rdata(cache_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stat_clr(stat_clr), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  initial clk_1 = 1'b0;
  always #5 clk_1 = ~clk_1;

  int n_vec  = 0;
  int n_err  = 0;
  int m_hit  = 0;
  int m_miss = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  // One CPU access. d = mem_req cycle in which the memory acks (0 or >TIMEOUT: never).
  task automatic do_txn(input bit we, input logic [15:0] addr, input logic [7:0] wd,
                        input bit hit, input logic [7:0] crd, input int d,
                        input logic [7:0] mrd, input bit clr_lookup, input bit spur);
    int k, mcyc, wen, lat, e_lat, e_mc;
    bit done, ack, e_wen, e_err;
    logic [7:0]  o_rd, fill_d, o_mwd, e_rd, e_fd;
    logic [15:0] fill_a, look_a, o_maddr;
    logic        o_err, o_mwe;
    k = 0; mcyc = 0; wen = 0; lat = 0; done = 1'b0;
    o_rd = '0; fill_d = '0; o_mwd = '0; fill_a = '0; look_a = '0; o_maddr = '0;
    o_err = 1'b0; o_mwe = 1'b0;
    chk("ready_before", 32'(cpu_ready), 32'd1);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    cache_hit = hit; cache_rdata = crd;
    while (!done && k < 400) begin
      @(posedge clk_1);
      @(negedge clk_1);
      k++;
      mem_ack  = (k == 1) && spur;
      stat_clr = (k == 1) && clr_lookup;
      if (k == 1) begin
        cpu_req = 1'b0;
        look_a  = cache_addr;
      end
      if (mem_req) begin
        mcyc++;
        if (mcyc == 1) begin
          o_maddr = mem_addr; o_mwe = mem_we; o_mwd = mem_wdata;
        end
        if (mcyc == d) begin
          mem_ack = 1'b1; mem_rdata = mrd;
        end
      end
      if (cache_w_en) begin
        wen++; fill_a = cache_addr; fill_d = cache_wdata;
      end
      if (cpu_valid) begin
        done = 1'b1; lat = k; o_rd = cpu_rdata; o_err = cpu_err;
      end
    end
    mem_ack = 1'b0; stat_clr = 1'b0;
    chk("completed", 32'(done), 32'd1);

    ack = (d >= 1) && (d <= TIMEOUT);
    e_err = (we || !hit) && !ack;
    if (we) begin
      e_lat = ack ? d + 2 : TIMEOUT + 1; e_mc = ack ? d : TIMEOUT;
      e_wen = ack; e_fd = wd; e_rd = '0;
    end else if (hit) begin
      e_lat = 2; e_mc = 0; e_wen = 1'b0; e_fd = '0; e_rd = crd;
    end else begin
      e_lat = ack ? d + 3 : TIMEOUT + 2; e_mc = ack ? d : TIMEOUT;
      e_wen = ack; e_fd = mrd; e_rd = ack ? mrd : 8'h00;
    end
    if (!we) begin
      if (hit) m_hit++; else m_miss++;
      if (clr_lookup) begin m_hit = 0; m_miss = 0; end
    end

    chk("latency", 32'(lat), 32'(e_lat));
    chk("cpu_rdata", 32'(o_rd), 32'(e_rd));
    chk("cpu_err", 32'(o_err), 32'(e_err));
    chk("mem_req_cycles", 32'(mcyc), 32'(e_mc));
    chk("cache_w_en_pulses", 32'(wen), 32'(e_wen));
    if (e_wen) begin
      chk("fill_addr", 32'(fill_a), 32'(addr));
      chk("fill_data", 32'(fill_d), 32'(e_fd));
    end
    if (!we) chk("lookup_addr", 32'(look_a), 32'(addr));
    if (e_mc > 0) begin
      chk("mem_addr", 32'(o_maddr), 32'(addr));
      chk("mem_we", 32'(o_mwe), 32'(we));
      if (we) chk("mem_wdata", 32'(o_mwd), 32'(wd));
    end
    @(posedge clk_1);
    @(negedge clk_1);
    chk("valid_one_cycle", 32'(cpu_valid), 32'd0);
    chk("ready_after", 32'(cpu_ready), 32'd1);
    chk("hit_cnt", 32'(hit_cnt), 32'(sat(m_hit)));
    chk("miss_cnt", 32'(miss_cnt), 32'(sat(m_miss)));
  endtask

  initial begin
    int w;
    bit r_we, r_hit, r_clr;
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    cache_hit = 1'b0; cache_rdata = '0; mem_ack = 1'b0; mem_rdata = '0; stat_clr = 1'b0;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk_1);
    chk("rst_cpu_ready", 32'(cpu_ready), 32'd1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_cache_w_en", 32'(cache_w_en), 32'd0);
    chk("rst_cpu_valid", 32'(cpu_valid), 32'd0);
    chk("rst_hit_cnt", 32'(hit_cnt), 32'd0);
    chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
    chk("rst_cache_addr", 32'(cache_addr), 32'd0);
    rst = 1'b1;
    @(negedge clk_1);

    do_txn(1'b0, 16'h1234, 8'h00, 1'b1, 8'h5A, 0, 8'h00, 1'b0, 1'b0);
    do_txn(1'b0, 16'h1234, 8'h00, 1'b0, 8'h11, 3, 8'hC3, 1'b0, 1'b0);
    do_txn(1'b1, 16'h0080, 8'h77, 1'b0, 8'h00, 1, 8'h00, 1'b0, 1'b0);
    do_txn(1'b0, 16'hBEEF, 8'h00, 1'b0, 8'h00, 0, 8'h00, 1'b0, 1'b0);
    do_txn(1'b1, 16'h0F0F, 8'hA5, 1'b0, 8'h00, 0, 8'h00, 1'b0, 1'b0);
    do_txn(1'b0, 16'h2222, 8'h00, 1'b0, 8'h00, TIMEOUT, 8'h3C, 1'b0, 1'b0);
    do_txn(1'b0, 16'h4321, 8'h00, 1'b1, 8'h9E, 0, 8'h00, 1'b0, 1'b1);
    do_txn(1'b0, 16'h00FF, 8'h00, 1'b1, 8'h42, 0, 8'h00, 1'b1, 1'b0);

    // Reset while a miss is waiting on memory
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h5555; cache_hit = 1'b0;
    w = 0;
    while (!mem_req && w < 10) begin
      @(posedge clk_1);
      @(negedge clk_1);
      cpu_req = 1'b0;
      w++;
    end
    chk("reached_miss_rd", 32'(mem_req), 32'd1);
    rst = 1'b0;
    #1;
    chk("async_mem_req_drop", 32'(mem_req), 32'd0);
    chk("async_cpu_ready", 32'(cpu_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_1);
      chk("no_valid_in_reset", 32'(cpu_valid), 32'd0);
    end
    rst = 1'b1;
    m_hit = 0; m_miss = 0;
    @(negedge clk_1);
    chk("post_rst_ready", 32'(cpu_ready), 32'd1);
    chk("post_rst_miss_cnt", 32'(miss_cnt), 32'd0);
    chk("post_rst_hit_cnt", 32'(hit_cnt), 32'd0);

    // Drive the hit counter into saturation
    for (int i = 0; i < CNT_MAX + 2; i++)
      do_txn(1'b0, 16'($urandom), 8'h00, 1'b1, 8'($urandom), 0, 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      r_we  = 1'($urandom_range(0, 1));
      r_hit = 1'($urandom_range(0, 1));
      r_clr = !r_we && ($urandom_range(0, 7) == 0);
      do_txn(r_we, 16'($urandom), 8'($urandom), r_hit, 8'($urandom),
             int'($urandom_range(1, 6)), 8'($urandom), r_clr, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
